qpp_extrinsic_buffer: RTL and testbench

Stores one block of extrinsic LLRs from the SISO decoder output (`extrinsic`/`valid_extrinsic`) and replays them, scaled by 0.75, as the `apriori`/`valid_apriori` stream for the next half-iteration. Each block is either interleaved or deinterleaved with the LTE QPP permutation pi(i) = (f1·i + f2·i²) mod K. The permutation is generated recursively, with no multipliers. The block sits directly downstream of the SISO decoder and loops back to its apriori input.

---
 rtl/qpp_extrinsic_buffer_if.sv | 28 ++
 rtl/qpp_extrinsic_buffer.sv | 172 +++++++++++++++++
 tb/tb_qpp_extrinsic_buffer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpp_extrinsic_buffer_if.sv
// Bus bundle between the SISO decoder loop and the QPP extrinsic buffer.
interface qpp_extrinsic_buffer_if #(
  parameter int unsigned DATA_W = 16
);
  logic [15:0]       blklen;
  logic [15:0]       f1;
  logic [15:0]       f2;
  logic              mode;
  logic              valid_blklen;
  logic [DATA_W-1:0] extrinsic;
  logic              valid_extrinsic;
  logic              rd_ready;
  logic [DATA_W-1:0] apriori;
  logic              valid_apriori;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output blklen, f1, f2, mode, valid_blklen, extrinsic, valid_extrinsic, rd_ready,
    input  apriori, valid_apriori, busy, done, err
  );

  modport slave (
    input  blklen, f1, f2, mode, valid_blklen, extrinsic, valid_extrinsic, rd_ready,
    output apriori, valid_apriori, busy, done, err
  );
endinterface

// File: rtl/qpp_extrinsic_buffer.sv
// Extrinsic LLR block buffer: stores one block, replays it QPP-(de)interleaved
// and scaled by 0.75 as the a-priori stream for the next half-iteration.
module qpp_extrinsic_buffer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MAX_LEN = 6144,
  parameter int unsigned ADDR_W  = 13
) (
  input logic                   clk,
  input logic                   rst,
  qpp_extrinsic_buffer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, READ} state_t;

  state_t state_q, state_nx;

  logic [ADDR_W-1:0] k_q, f1_q, f2_q;
  logic              mode_q;
  logic [ADDR_W-1:0] g0_q, g_q, d_q, pi_q, i_q;
  logic [ADDR_W-1:0] g_init, d_init, pi_nx, g_nx;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              last_i, blklen_ok;
  logic              ld_cfg, do_setup, step, rewind, wr_en, rd_issue, err_nx;

  logic [DATA_W-1:0] mem [MAX_LEN];
  logic [DATA_W-1:0] rd_data;
  logic signed [DATA_W-1:0] rd_s, scaled;
  logic              rd_v1_q, rd_last1_q;

  // (a + b) mod k for operands already below k: one conditional subtract
  function automatic logic [ADDR_W-1:0] add_mod(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b,
                                                input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[ADDR_W-1:0];
  endfunction

  assign g_init    = add_mod(f1_q, f2_q, k_q);
  assign d_init    = add_mod(f2_q, f2_q, k_q);
  assign pi_nx     = add_mod(pi_q, g_q, k_q);
  assign g_nx      = add_mod(g_q, d_q, k_q);
  assign last_i    = (i_q == k_q - ADDR_W'(1));
  assign blklen_ok = (bus.blklen != 16'd0) && (32'(bus.blklen) <= MAX_LEN);
  assign wr_addr   = mode_q ? pi_q : i_q;
  assign rd_addr   = mode_q ? i_q  : pi_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    ld_cfg   = 1'b0;
    do_setup = 1'b0;
    step     = 1'b0;
    rewind   = 1'b0;
    wr_en    = 1'b0;
    rd_issue = 1'b0;
    err_nx   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.valid_blklen) begin
          if (blklen_ok) begin
            ld_cfg   = 1'b1;
            state_nx = SETUP;
          end else begin
            err_nx = 1'b1;
          end
        end
        if (bus.valid_extrinsic) err_nx = 1'b1;
      end
      SETUP: begin
        do_setup = 1'b1;
        state_nx = WRITE;
        if (bus.valid_blklen || bus.valid_extrinsic) err_nx = 1'b1;
      end
      WRITE: begin
        if (bus.valid_blklen) err_nx = 1'b1;
        if (bus.valid_extrinsic) begin
          wr_en = 1'b1;
          step  = 1'b1;
          if (last_i) begin
            rewind   = 1'b1;
            state_nx = READ;
          end
        end
      end
      READ: begin
        if (bus.valid_blklen || bus.valid_extrinsic) err_nx = 1'b1;
        if (bus.rd_ready) begin
          rd_issue = 1'b1;
          step     = 1'b1;
          if (last_i) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Block configuration and recursive permutation counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_q    <= '0;
      f1_q   <= '0;
      f2_q   <= '0;
      mode_q <= 1'b0;
      g0_q   <= '0;
      g_q    <= '0;
      d_q    <= '0;
      pi_q   <= '0;
      i_q    <= '0;
    end else begin
      if (ld_cfg) begin
        k_q    <= ADDR_W'(bus.blklen);
        f1_q   <= ADDR_W'(bus.f1);
        f2_q   <= ADDR_W'(bus.f2);
        mode_q <= bus.mode;
      end
      if (do_setup) begin
        g0_q <= g_init;
        g_q  <= g_init;
        d_q  <= d_init;
        pi_q <= '0;
        i_q  <= '0;
      end else if (rewind) begin
        g_q  <= g0_q;
        pi_q <= '0;
        i_q  <= '0;
      end else if (step) begin
        g_q  <= g_nx;
        pi_q <= pi_nx;
        i_q  <= i_q + ADDR_W'(1);
      end
    end
  end

  // Block RAM: no reset so it maps onto a synchronous-read macro
  always_ff @(posedge clk) begin
    if (wr_en)    mem[wr_addr] <= bus.extrinsic;
    if (rd_issue) rd_data      <= mem[rd_addr];
  end

  always_comb begin
    rd_s   = rd_data;
    scaled = rd_s - (rd_s >>> 2);
  end

  // Read pipeline and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1_q           <= 1'b0;
      rd_last1_q        <= 1'b0;
      bus.apriori       <= '0;
      bus.valid_apriori <= 1'b0;
      bus.done          <= 1'b0;
      bus.busy          <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      rd_v1_q           <= rd_issue;
      rd_last1_q        <= rd_issue && last_i;
      bus.valid_apriori <= rd_v1_q;
      bus.done          <= rd_last1_q;
      if (rd_v1_q) bus.apriori <= scaled;
      bus.busy          <= (state_nx != IDLE);
      bus.err           <= err_nx;
    end
  end

endmodule

// File: tb/tb_qpp_extrinsic_buffer.sv
// Randomised self-checking bench: QPP (de)interleave + 0.75 scaling against a direct-formula model.
module tb_qpp_extrinsic_buffer;

  localparam int MAX_LEN = 6144;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  qpp_extrinsic_buffer_if #(.DATA_W(16)) bus ();

  qpp_extrinsic_buffer #(.DATA_W(16), .MAX_LEN(MAX_LEN), .ADDR_W(13)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   got[$];
  int   din[MAX_LEN];
  int   checks   = 0;
  int   failures = 0;
  int   err_cnt  = 0;
  int   done_cnt = 0;

  int tk [6] = '{8, 40, 48, 56, 64, 104};
  int tf1[6] = '{3, 3, 7, 19, 7, 7};
  int tf2[6] = '{2, 10, 12, 42, 16, 26};

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // 0.75*x with the quarter term floored: x - floor(x/4)
  function automatic int scale(input int x);
    int q;
    q = x / 4;
    if (x < 0 && (x % 4) != 0) q = q - 1;
    return x - q;
  endfunction

  function automatic int qpp(input int i, input int k, input int f1, input int f2);
    longint v;
    v = (longint'(f1) * i + longint'(f2) * i * i) % k;
    return int'(v);
  endfunction

  task automatic model_push(input int k, input int f1, input int f2, input int m);
    int mem[];
    exp_t e;
    mem = new[k];
    if (m == 0) begin
      for (int j = 0; j < k; j++) mem[j] = din[qpp(j, k, f1, f2)];
    end else begin
      for (int i = 0; i < k; i++) mem[qpp(i, k, f1, f2)] = din[i];
    end
    for (int j = 0; j < k; j++) begin
      e.data = scale(mem[j]);
      e.last = (j == k - 1);
      exp_q.push_back(e);
    end
  endtask

  // Compare process: every output beat against the model queue
  always @(negedge clk) begin
    if (rst) begin
      if (bus.err)  err_cnt++;
      if (bus.done) done_cnt++;
      if (bus.valid_apriori) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid_apriori", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("apriori", int'($signed(bus.apriori)), e.data);
          chk("done_on_beat", int'(bus.done), int'(e.last));
          got.push_back(int'($signed(bus.apriori)));
        end
      end else if (bus.done) begin
        chk("done_without_valid", 1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input int k, input int f1, input int f2, input int m);
    bus.blklen       = 16'(k);
    bus.f1           = 16'(f1);
    bus.f2           = 16'(f2);
    bus.mode         = m[0];
    bus.valid_blklen = 1'b1;
    tick();
    bus.valid_blklen = 1'b0;
    tick();
  endtask

  task automatic write_block(input int k, input int gap_pct, input int inject_at);
    for (int i = 0; i < k; i++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        bus.valid_extrinsic = 1'b0;
        tick();
      end
      bus.valid_extrinsic = 1'b1;
      bus.extrinsic       = 16'(din[i]);
      if (i == inject_at) begin
        bus.blklen       = 16'd5;
        bus.valid_blklen = 1'b1;
      end
      tick();
      bus.valid_blklen = 1'b0;
    end
    bus.valid_extrinsic = 1'b0;
  endtask

  task automatic read_block(input int rdpat);
    int d0;
    int cyc;
    d0  = done_cnt;
    cyc = 0;
    while (done_cnt == d0 && cyc < 30000) begin
      case (rdpat)
        0:       bus.rd_ready = 1'b1;
        1:       bus.rd_ready = ~cyc[0];
        default: bus.rd_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      cyc++;
    end
    bus.rd_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic run_block(input int k, input int f1, input int f2, input int m,
                           input int rdpat, input int gap_pct, input int inject_at);
    int d0;
    got.delete();
    model_push(k, f1, f2, m);
    d0 = done_cnt;
    start_block(k, f1, f2, m);
    write_block(k, gap_pct, inject_at);
    read_block(rdpat);
    chk("beat_count", got.size(), k);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    int e0;
    int k, f1, f2, m, sel;
    bus.blklen          = '0;
    bus.f1              = '0;
    bus.f2              = '0;
    bus.mode            = 1'b0;
    bus.valid_blklen    = 1'b0;
    bus.extrinsic       = '0;
    bus.valid_extrinsic = 1'b0;
    bus.rd_ready        = 1'b1;

    repeat (3) tick();
    chk("rst_apriori", int'(bus.apriori), 0);
    chk("rst_valid", int'(bus.valid_apriori), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    rst = 1'b1;
    tick();

    // Interleave K=40
    for (int i = 0; i < 40; i++) din[i] = 4 * i;
    run_block(40, 3, 10, 0, 0, 0, -1);
    if (got.size() >= 4) begin
      chk("il_lit0", got[0], 0);
      chk("il_lit1", got[1], 39);
      chk("il_lit2", got[2], 18);
      chk("il_lit3", got[3], 57);
    end else chk("il_lit_short", got.size(), 4);

    // Round trip: undo the 0.75 on the interleaved output and deinterleave
    if (got.size() == 40) for (int i = 0; i < 40; i++) din[i] = (got[i] * 4) / 3;
    run_block(40, 3, 10, 1, 0, 0, -1);
    if (got.size() == 40) for (int j = 0; j < 40; j++) chk("roundtrip_lit", got[j], 3 * j);

    // Scaling extremes through identity permutation
    din[0] = -32768; din[1] = 32767; din[2] = -5; din[3] = 0;
    run_block(4, 1, 0, 0, 0, 0, -1);
    if (got.size() == 4) begin
      chk("scale_neg_max", got[0], -24576);
      chk("scale_pos_max", got[1], 24576);
      chk("scale_m5", got[2], -3);
      chk("scale_zero", got[3], 0);
    end

    // Backpressure: rd_ready toggling
    for (int i = 0; i < 40; i++) din[i] = int'($urandom_range(0, 65535)) - 32768;
    run_block(40, 3, 10, 0, 1, 0, -1);

    // Error: zero block length
    e0 = err_cnt;
    bus.blklen = 16'd0; bus.valid_blklen = 1'b1;
    tick();
    bus.valid_blklen = 1'b0;
    tick();
    chk("err_blklen0", err_cnt - e0, 1);
    chk("busy_after_blklen0", int'(bus.busy), 0);

    // Error: extrinsic while idle
    e0 = err_cnt;
    bus.valid_extrinsic = 1'b1; bus.extrinsic = 16'h1234;
    tick();
    bus.valid_extrinsic = 1'b0;
    tick();
    chk("err_ext_idle", err_cnt - e0, 1);
    chk("busy_after_ext_idle", int'(bus.busy), 0);

    // Error: block start during WRITE must not disturb the block
    for (int i = 0; i < 48; i++) din[i] = int'($urandom_range(0, 65535)) - 32768;
    e0 = err_cnt;
    run_block(48, 7, 12, 1, 0, 20, 17);
    chk("err_blklen_in_write", err_cnt - e0, 1);

    // Randomised blocks
    e0 = err_cnt;
    for (int b = 0; b < 10; b++) begin
      m   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 5));
      if (m == 1 || b % 3 == 0) begin
        k = tk[sel]; f1 = tf1[sel]; f2 = tf2[sel];
      end else begin
        k  = int'($urandom_range(1, 200));
        f1 = int'($urandom_range(0, k - 1));
        f2 = int'($urandom_range(0, k - 1));
      end
      for (int i = 0; i < k; i++) din[i] = int'($urandom_range(0, 65535)) - 32768;
      run_block(k, f1, f2, m, int'($urandom_range(0, 2)), 30, -1);
    end
    for (int i = 0; i < MAX_LEN; i++) din[i] = int'($urandom_range(0, 65535)) - 32768;
    run_block(MAX_LEN, 263, 480, 1, 2, 10, -1);
    k = 1;
    din[0] = -7;
    run_block(1, 0, 0, 0, 0, 0, -1);
    chk("no_err_random", err_cnt - e0, 0);

    // Reset in the middle of WRITE
    for (int i = 0; i < 40; i++) din[i] = i + 1;
    start_block(40, 3, 10, 0);
    write_block(10, 0, -1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_apriori", int'(bus.apriori), 0);
    chk("midrst_valid", int'(bus.valid_apriori), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    chk("midrst_err", int'(bus.err), 0);
    tick();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) din[i] = int'($urandom_range(0, 65535)) - 32768;
    run_block(8, 3, 2, 1, 2, 0, -1);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
